mem_master: RTL and testbench

- Initiator-side controller for the team's single-port synchronous word memory (sel/str/ld/clr control, 1-cycle registered read data).
- Accepts read, write and clear commands from the CPU/datapath side with valid/ready handshakes; runs bursts with an auto-incrementing address; drives the memory control pins.
- Captures returned read data into a holding register with backpressure.
- Sits between the core's load/store unit and the data memory.

---
 rtl/mem_master.sv | 195 +++++++++++++++++++
 tb/tb_mem_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_master.sv
// Initiator-side controller for the single-port word memory. It runs read, write and clear bursts.
// All outputs are registered. With MEM_MASTER_WRITE_VERIFY_EN, each written word is read back and compared.
module mem_master #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [LEN_BITS-1:0]  req_len,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DATA_BITS-1:0] wr_data,
    output logic                 rd_valid,
    input  logic                 rd_ready,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 done,
    output logic                 err,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0] mem_din,
    output logic                 mem_sel,
    output logic                 mem_str,
    output logic                 mem_ld,
    output logic                 mem_clr,
    input  logic [DATA_BITS-1:0] mem_dout
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] RD_ISSUE = 4'd1;
    localparam logic [3:0] RD_CAPT  = 4'd2;
    localparam logic [3:0] RD_HOLD  = 4'd3;
    localparam logic [3:0] WR_WAIT  = 4'd4;
    localparam logic [3:0] WR_ISSUE = 4'd5;
    localparam logic [3:0] CLR      = 4'd6;
    localparam logic [3:0] FIN      = 4'd7;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
    localparam logic [3:0] VF_ISSUE = 4'd8;
    localparam logic [3:0] VF_CAPT  = 4'd9;
    logic vf_err;
`endif

    logic [3:0]           state;
    logic [ADDR_BITS-1:0] addr_q;
    logic [LEN_BITS-1:0]  beats_q;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            beats_q   <= '0;
            req_ready <= 1'b1;
            wr_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            mem_sel   <= 1'b0;
            mem_str   <= 1'b0;
            mem_ld    <= 1'b0;
            mem_clr   <= 1'b0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
            vf_err    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr;
                        beats_q   <= req_len;
                        req_ready <= 1'b0;
`ifdef MEM_MASTER_WRITE_VERIFY_EN
                        vf_err    <= 1'b0;
`endif
                        case (req_op)
                            2'b00: begin
                                state    <= RD_ISSUE;
                                mem_sel  <= 1'b1;
                                mem_ld   <= 1'b1;
                                mem_addr <= req_addr;
                            end
                            2'b01: begin
                                state    <= WR_WAIT;
                                wr_ready <= 1'b1;
                            end
                            2'b10: begin
                                state   <= CLR;
                                mem_clr <= 1'b1;
                            end
                            default: begin
                                state <= FIN;
                                done  <= 1'b1;
                                err   <= 1'b1;
                            end
                        endcase
                    end
                end
                RD_ISSUE: begin
                    mem_sel <= 1'b0;
                    mem_ld  <= 1'b0;
                    state   <= RD_CAPT;
                end
                RD_CAPT: begin
                    rd_data  <= mem_dout;
                    rd_valid <= 1'b1;
                    state    <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (beats_q != '0) begin
                            beats_q  <= beats_q - 1'b1;
                            addr_q   <= addr_q + 1'b1;
                            mem_addr <= addr_q + 1'b1;
                            mem_sel  <= 1'b1;
                            mem_ld   <= 1'b1;
                            state    <= RD_ISSUE;
                        end else begin
                            state <= FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                WR_WAIT: begin
                    if (wr_valid && wr_ready) begin
                        mem_din  <= wr_data;
                        mem_addr <= addr_q;
                        mem_sel  <= 1'b1;
                        mem_str  <= 1'b1;
                        wr_ready <= 1'b0;
                        state    <= WR_ISSUE;
                    end
                end
`ifdef MEM_MASTER_WRITE_VERIFY_EN
                WR_ISSUE: begin
                    // Read the same word straight back; mem_addr still holds it.
                    mem_str <= 1'b0;
                    mem_ld  <= 1'b1;
                    state   <= VF_ISSUE;
                end
                VF_ISSUE: begin
                    mem_sel <= 1'b0;
                    mem_ld  <= 1'b0;
                    state   <= VF_CAPT;
                end
                VF_CAPT: begin
                    if (mem_dout != mem_din) vf_err <= 1'b1;
                    if (beats_q != '0) begin
                        beats_q  <= beats_q - 1'b1;
                        addr_q   <= addr_q + 1'b1;
                        wr_ready <= 1'b1;
                        state    <= WR_WAIT;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                        err   <= vf_err || (mem_dout != mem_din);
                    end
                end
`else
                WR_ISSUE: begin
                    mem_sel <= 1'b0;
                    mem_str <= 1'b0;
                    if (beats_q != '0) begin
                        beats_q  <= beats_q - 1'b1;
                        addr_q   <= addr_q + 1'b1;
                        wr_ready <= 1'b1;
                        state    <= WR_WAIT;
                    end else begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
`endif
                CLR: begin
                    mem_clr <= 1'b0;
                    state   <= FIN;
                    done    <= 1'b1;
                end
                FIN: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Scoreboarded bench for mem_master with a behavioural single-port memory.
module tb_mem_master;
    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [9:0]  req_addr = '0;
    logic [3:0]  req_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = '0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        done, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din, mem_dout, mem_q;
    logic        mem_sel, mem_str, mem_ld, mem_clr;
    logic        corrupt = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int ld_cnt = 0, sel_cnt = 0, clr_cnt = 0, done_cnt = 0;
    logic [31:0] exp_q[$];
    logic [9:0]  wr_log[$];
    logic [9:0]  rd_log[$];
    logic [31:0] mem_arr [1024];

    always #5 clk = ~clk;

    mem_master dut (
        .clk(clk), .clr_n(clr_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .done(done), .err(err),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_sel(mem_sel),
        .mem_str(mem_str), .mem_ld(mem_ld), .mem_clr(mem_clr),
        .mem_dout(mem_dout)
    );

    initial for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
    initial mem_q = '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= '0;
        end else begin
            if (mem_sel && mem_str) mem_arr[mem_addr] <= mem_din;
            if (mem_sel && mem_ld)  mem_q <= mem_arr[mem_addr];
        end
    end
    assign mem_dout = mem_q ^ {31'b0, corrupt};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: logs memory activity and retires read beats against the scoreboard.
    always @(negedge clk) begin
        if (mem_sel && mem_str) begin wr_log.push_back(mem_addr); sel_cnt++; end
        if (mem_sel && mem_ld)  begin rd_log.push_back(mem_addr); ld_cnt++; end
        if (mem_sel && !mem_str && !mem_ld) sel_cnt++;
        if (mem_clr) clr_cnt++;
        if (done) done_cnt++;
        if (mem_str && mem_ld) chk("str_ld_excl", 1, 0);
        if (mem_clr && mem_sel) chk("clr_sel_excl", 1, 0);
        if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else chk("rd_beat", rd_data, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [9:0] a, input logic [3:0] len);
        int n = 0;
        while (!req_ready && n < 100) begin step(); n++; end
        chk("req_ready", req_ready, 1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_len = len;
        step();
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0; req_len = '0;
    endtask

    task automatic write_beat(input logic [31:0] d, input int stall);
        int n = 0;
        repeat (stall) step();
        wr_valid = 1'b1; wr_data = d;
        while (!wr_ready && n < 50) begin step(); n++; end
        chk("wr_ready", wr_ready, 1);
        step();
        wr_valid = 1'b0; wr_data = '0;
    endtask

    task automatic wait_done(input logic exp_err);
        int n = 0;
        int d0;
        d0 = done_cnt;
        while (!done && n < 100) begin step(); n++; end
        chk("done", done, 1);
        chk("err", err, exp_err);
        step();
        chk("done_1cyc", done, 0);
        chk("done_once", done_cnt - d0, 1);
        chk("req_ready_back", req_ready, 1);
    endtask

    task automatic wait_rd_valid();
        int n = 0;
        while (!rd_valid && n < 50) begin step(); n++; end
        chk("rd_valid_seen", rd_valid, 1);
    endtask

    initial begin
        int s, l;
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_ctl", {mem_sel, mem_str, mem_ld, mem_clr}, 0);
        step();
        clr_n = 1'b1;
        step();

        // 1: single write then single read
        wr_log.delete(); rd_ready = 1'b1;
        send_cmd(2'b01, 10'h005, 4'd0);
        write_beat(32'hDEADBEEF, 0);
        wait_done(1'b0);
        chk("t1_wr_cnt", wr_log.size(), 1);
        chk("t1_wr_addr", wr_log[0], 10'h005);
        exp_q.push_back(32'hDEADBEEF);
        send_cmd(2'b00, 10'h005, 4'd0);
        step();
        chk("t1_rv_early", rd_valid, 0);
        step();
        chk("t1_rv_lat", rd_valid, 1);
        chk("t1_rd_data", rd_data, 32'hDEADBEEF);
        wait_done(1'b0);

        // 2: wrapping burst write with a stall, read back
        wr_log.delete(); rd_log.delete();
        send_cmd(2'b01, 10'h3FE, 4'd3);
        for (int i = 0; i < 4; i++) write_beat(i + 1, (i == 2) ? 2 : 0);
        wait_done(1'b0);
        chk("t2_wr_cnt", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_wr_addr", wr_log[i], 10'(10'h3FE + i));
        for (int i = 0; i < 4; i++) exp_q.push_back(i + 1);
        send_cmd(2'b00, 10'h3FE, 4'd3);
        wait_done(1'b0);
        chk("t2_rd_cnt", rd_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_rd_addr", rd_log[i], 10'(10'h3FE + i));
        chk("t2_sb_empty", exp_q.size(), 0);

        // 3: read backpressure on beat 1
        rd_log.delete(); rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(i + 1);
        send_cmd(2'b00, 10'h3FE, 4'd2);
        for (int b = 0; b < 3; b++) begin
            wait_rd_valid();
            if (b == 1) begin
                l = ld_cnt;
                repeat (5) begin
                    step();
                    chk("t3_hold_vld", rd_valid, 1);
                    chk("t3_hold_dat", rd_data, 2);
                end
                chk("t3_no_ld", ld_cnt - l, 0);
            end
            rd_ready = 1'b1;
            step();
            rd_ready = 1'b0;
        end
        wait_done(1'b0);
        chk("t3_beats", rd_log.size(), 3);
        chk("t3_sb_empty", exp_q.size(), 0);

        // 4: clear wipes a written word
        rd_ready = 1'b1;
        send_cmd(2'b01, 10'h010, 4'd0);
        write_beat(32'h1234, 0);
        wait_done(1'b0);
        s = clr_cnt;
        send_cmd(2'b10, 10'h000, 4'd0);
        wait_done(1'b0);
        chk("t4_clr_cyc", clr_cnt - s, 1);
        exp_q.push_back(32'h0);
        send_cmd(2'b00, 10'h010, 4'd0);
        wait_done(1'b0);
        chk("t4_sb_empty", exp_q.size(), 0);

        // 5: reserved op
        s = sel_cnt; l = clr_cnt;
        send_cmd(2'b11, 10'h0AA, 4'd5);
        wait_done(1'b1);
        chk("t5_no_sel", sel_cnt - s, 0);
        chk("t5_no_clr", clr_cnt - l, 0);

        // 6: reset mid write burst
        send_cmd(2'b01, 10'h020, 4'd3);
        write_beat(32'hA5A5A5A5, 0);
        step();
        s = done_cnt;
        #2 clr_n = 1'b0;
        #1;
        chk("t6_wr_ready", wr_ready, 0);
        chk("t6_mem_ctl", {mem_sel, mem_str, mem_ld, mem_clr}, 0);
        chk("t6_rd_valid", rd_valid, 0);
        chk("t6_done", done, 0);
        step();
        clr_n = 1'b1;
        repeat (3) step();
        chk("t6_req_ready", req_ready, 1);
        chk("t6_no_done", done_cnt - s, 0);
        exp_q.push_back(32'hA5A5A5A5);
        send_cmd(2'b00, 10'h020, 4'd0);
        wait_done(1'b0);
        chk("t6_sb_empty", exp_q.size(), 0);

`ifdef MEM_MASTER_WRITE_VERIFY_EN
        corrupt = 1'b1;
        send_cmd(2'b01, 10'h030, 4'd0);
        write_beat(32'h55AA55AA, 0);
        wait_done(1'b1);
        corrupt = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
